// File: rtl/kpn_pkg.sv
// rtl/kpn_pkg.sv - shared constants and helper functions for KPN channel modules
package kpn_pkg;

    localparam int KPN_TOKEN_BITS = 16;

    function automatic int kpn_count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Precharge token i, computed at 64 bits; callers keep the low token-width bits
    function automatic logic [63:0] kpn_precharge_token(input longint value, input longint step,
                                                        input int idx);
        return 64'(value + step * longint'(idx));
    endfunction

endpackage

// File: rtl/kpn_queue_precharged_if.sv
// rtl/kpn_queue_precharged_if.sv - producer/consumer handshake and status bundle of the queue
interface kpn_queue_precharged_if #(
    parameter int BITS_NUMBER   = 16,
    parameter int FIFO_ELEMENTS = 5
);
    import kpn_pkg::*;

    localparam int CW = kpn_count_width(FIFO_ELEMENTS);

    logic                   rd;
    logic                   wr;
    logic [BITS_NUMBER-1:0] entry_1;
    logic [BITS_NUMBER-1:0] output_1;
    logic                   valid_1;
    logic                   full;
    logic                   empty;
    logic [CW-1:0]          count;
    logic                   overflow;
    logic                   underflow;

    modport master (
        output rd, wr, entry_1,
        input  output_1, valid_1, full, empty, count, overflow, underflow
    );

    modport slave (
        input  rd, wr, entry_1,
        output output_1, valid_1, full, empty, count, overflow, underflow
    );

endinterface

// File: rtl/kpn_wrap_pointer.sv
// rtl/kpn_wrap_pointer.sv - modulo-DEPTH pointer that wraps by explicit compare
module kpn_wrap_pointer #(
    parameter int DEPTH       = 5,
    parameter int RESET_VALUE = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inc,
    output logic [$clog2(DEPTH)-1:0] ptr
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] ptr_d;
    logic [PW-1:0] ptr_q;

    // Non-power-of-2 depths must never see the binary rollover values
    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            if (ptr_q == PW'(DEPTH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= PW'(RESET_VALUE);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/kpn_queue_precharged.sv
// rtl/kpn_queue_precharged.sv - precharged KPN channel FIFO with registered read and sticky error flags
module kpn_queue_precharged
    import kpn_pkg::*;
#(
    parameter int BITS_NUMBER              = KPN_TOKEN_BITS,
    parameter int FIFO_ELEMENTS            = 5,
    parameter int NUMBER_OF_PRECHARGE_DATA = 4,
    parameter int PRECHARGE_VALUE          = 0,
    parameter int PRECHARGE_STEP           = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    kpn_queue_precharged_if.slave  q
);

    localparam int CW = kpn_count_width(FIFO_ELEMENTS);
    localparam int PW = $clog2(FIFO_ELEMENTS);

    if (FIFO_ELEMENTS < 2) begin : g_bad_depth
        $error("kpn_queue_precharged: FIFO_ELEMENTS must be at least 2");
    end
    if (NUMBER_OF_PRECHARGE_DATA > FIFO_ELEMENTS) begin : g_bad_precharge
        $error("kpn_queue_precharged: NUMBER_OF_PRECHARGE_DATA exceeds FIFO_ELEMENTS");
    end

    function automatic logic [BITS_NUMBER-1:0] token_at(input int idx);
        logic [63:0] t;
        t = kpn_precharge_token(PRECHARGE_VALUE, PRECHARGE_STEP, idx);
        return t[BITS_NUMBER-1:0];
    endfunction

    logic [BITS_NUMBER-1:0] mem_q [FIFO_ELEMENTS];
    logic [PW-1:0]          rd_ptr;
    logic [PW-1:0]          wr_ptr;

    logic [CW-1:0]          count_d,    count_q;
    logic [BITS_NUMBER-1:0] out_d,      out_q;
    logic                   valid_d,    valid_q;
    logic                   overflow_d, overflow_q;
    logic                   underflow_d, underflow_q;

    logic full_w;
    logic empty_w;
    logic rd_acc;
    logic wr_acc;

    assign full_w  = (count_q == CW'(FIFO_ELEMENTS));
    assign empty_w = (count_q == '0);

    // A read frees a slot in the same cycle, so a full queue still accepts rd+wr
    always_comb begin
        rd_acc      = q.rd && !empty_w;
        wr_acc      = q.wr && (!full_w || rd_acc);
        count_d     = count_q;
        out_d       = out_q;
        valid_d     = rd_acc;
        overflow_d  = overflow_q  | (q.wr && !wr_acc);
        underflow_d = underflow_q | (q.rd && !rd_acc);
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end
        if (rd_acc) begin
            out_d = mem_q[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUMBER_OF_PRECHARGE_DATA; i++) begin
                mem_q[i] <= token_at(i);
            end
        end else if (wr_acc) begin
            mem_q[wr_ptr] <= q.entry_1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= CW'(NUMBER_OF_PRECHARGE_DATA);
            out_q       <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    kpn_wrap_pointer #(
        .DEPTH       (FIFO_ELEMENTS),
        .RESET_VALUE (0)
    ) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (rd_acc),
        .ptr   (rd_ptr)
    );

    kpn_wrap_pointer #(
        .DEPTH       (FIFO_ELEMENTS),
        .RESET_VALUE (NUMBER_OF_PRECHARGE_DATA % FIFO_ELEMENTS)
    ) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (wr_acc),
        .ptr   (wr_ptr)
    );

    assign q.output_1  = out_q;
    assign q.valid_1   = valid_q;
    assign q.full      = full_w;
    assign q.empty     = empty_w;
    assign q.count     = count_q;
    assign q.overflow  = overflow_q;
    assign q.underflow = underflow_q;

endmodule

// File: tb/tb_kpn_queue_precharged.sv
// tb/tb_kpn_queue_precharged.sv - vector table, corner sequences and random traffic against a queue model
module tb_kpn_queue_precharged;

    localparam int DEPTH = 5;
    localparam int NPRE  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    kpn_queue_precharged_if #(.BITS_NUMBER(16), .FIFO_ELEMENTS(DEPTH)) if_a ();
    kpn_queue_precharged_if #(.BITS_NUMBER(16), .FIFO_ELEMENTS(DEPTH)) if_b ();

    kpn_queue_precharged #(
        .BITS_NUMBER(16), .FIFO_ELEMENTS(DEPTH), .NUMBER_OF_PRECHARGE_DATA(NPRE),
        .PRECHARGE_VALUE(0), .PRECHARGE_STEP(1)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .q     (if_a)
    );

    kpn_queue_precharged #(
        .BITS_NUMBER(16), .FIFO_ELEMENTS(DEPTH), .NUMBER_OF_PRECHARGE_DATA(0),
        .PRECHARGE_VALUE(0), .PRECHARGE_STEP(1)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .q     (if_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          rst;
        bit          rd;
        bit          wr;
        logic [15:0] data;
        bit          exp_valid;
        logic [15:0] exp_out;
        int          exp_count;
        bit          exp_ovf;
        bit          exp_udf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rs, input bit r, input bit w, input logic [15:0] d,
                       input bit ev, input logic [15:0] eo, input int ec,
                       input bit eovf, input bit eudf);
        vec_t v;
        v = '{rs, r, w, d, ev, eo, ec, eovf, eudf};
        vecs.push_back(v);
    endtask

    // Behavioural model: a token queue plus output/flag state
    logic [15:0] mq[$];
    logic [15:0] m_out;
    bit          m_valid, m_ovf, m_udf;

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < NPRE; i++) mq.push_back(16'(i));
        m_out = '0; m_valid = 0; m_ovf = 0; m_udf = 0;
    endtask

    task automatic model_step(input bit r, input bit w, input logic [15:0] d);
        bit ra, wa;
        ra = r && (mq.size() > 0);
        wa = w && ((mq.size() < DEPTH) || ra);
        m_valid = ra;
        if (ra) m_out = mq.pop_front();
        if (wa) mq.push_back(d);
        if (r && !ra) m_udf = 1;
        if (w && !wa) m_ovf = 1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, 32'(if_a.valid_1), 32'(m_valid));
        chk({tag, ".out"}, 32'(if_a.output_1), 32'(m_out));
        chk({tag, ".count"}, 32'(if_a.count), mq.size());
        chk({tag, ".full"}, 32'(if_a.full), 32'(mq.size() == DEPTH));
        chk({tag, ".empty"}, 32'(if_a.empty), 32'(mq.size() == 0));
        chk({tag, ".ovf"}, 32'(if_a.overflow), 32'(m_ovf));
        chk({tag, ".udf"}, 32'(if_a.underflow), 32'(m_udf));
    endtask

    task automatic step(input bit rs, input bit r, input bit w, input logic [15:0] d,
                        input string tag);
        reset = rs; if_a.rd = r; if_a.wr = w; if_a.entry_1 = d;
        @(posedge clk); #1;
        if (rs) model_reset(); else model_step(r, w, d);
        reset = 0; if_a.rd = 0; if_a.wr = 0;
        check_model(tag);
    endtask

    initial begin
        reset = 1; if_a.rd = 0; if_a.wr = 0; if_a.entry_1 = '0;
        if_b.rd = 0; if_b.wr = 0; if_b.entry_1 = '0;

        //   rst rd wr data     valid out      cnt ovf udf
        add(1, 0, 0, 16'h0000, 0, 16'h0000, 4, 0, 0);
        add(0, 1, 0, 16'h0000, 1, 16'h0000, 3, 0, 0);
        add(0, 1, 0, 16'h0000, 1, 16'h0001, 2, 0, 0);
        add(0, 1, 0, 16'h0000, 1, 16'h0002, 1, 0, 0);
        add(0, 1, 0, 16'h0000, 1, 16'h0003, 0, 0, 0);
        add(0, 0, 0, 16'h0000, 0, 16'h0003, 0, 0, 0);
        add(0, 1, 1, 16'h0055, 0, 16'h0003, 1, 0, 1);
        add(0, 1, 0, 16'h0000, 1, 16'h0055, 0, 0, 1);
        add(1, 0, 0, 16'h0000, 0, 16'h0000, 4, 0, 0);
        add(0, 0, 1, 16'hAAAA, 0, 16'h0000, 5, 0, 0);
        add(0, 0, 1, 16'hBBBB, 0, 16'h0000, 5, 1, 0);
        add(0, 1, 1, 16'h1234, 1, 16'h0000, 5, 1, 0);
        add(0, 1, 0, 16'h0000, 1, 16'h0001, 4, 1, 0);
        add(0, 1, 0, 16'h0000, 1, 16'h0002, 3, 1, 0);
        add(0, 1, 0, 16'h0000, 1, 16'h0003, 2, 1, 0);
        add(0, 1, 0, 16'h0000, 1, 16'hAAAA, 1, 1, 0);
        add(0, 1, 0, 16'h0000, 1, 16'h1234, 0, 1, 0);
        add(0, 1, 0, 16'h0000, 0, 16'h1234, 0, 1, 1);
        add(0, 0, 1, 16'h0007, 0, 16'h1234, 1, 1, 1);
        add(0, 0, 1, 16'h0008, 0, 16'h1234, 2, 1, 1);
        add(1, 1, 1, 16'hDEAD, 0, 16'h0000, 4, 0, 0);
        add(0, 1, 0, 16'h0000, 1, 16'h0000, 3, 0, 0);

        foreach (vecs[k]) begin
            reset = vecs[k].rst; if_a.rd = vecs[k].rd; if_a.wr = vecs[k].wr;
            if_a.entry_1 = vecs[k].data;
            @(posedge clk); #1;
            chk($sformatf("vec%0d.valid", k), 32'(if_a.valid_1), 32'(vecs[k].exp_valid));
            chk($sformatf("vec%0d.out", k), 32'(if_a.output_1), 32'(vecs[k].exp_out));
            chk($sformatf("vec%0d.count", k), 32'(if_a.count), vecs[k].exp_count);
            chk($sformatf("vec%0d.full", k), 32'(if_a.full), 32'(vecs[k].exp_count == DEPTH));
            chk($sformatf("vec%0d.empty", k), 32'(if_a.empty), 32'(vecs[k].exp_count == 0));
            chk($sformatf("vec%0d.ovf", k), 32'(if_a.overflow), 32'(vecs[k].exp_ovf));
            chk($sformatf("vec%0d.udf", k), 32'(if_a.underflow), 32'(vecs[k].exp_udf));
            if (vecs[k].rst) begin
                chk($sformatf("vec%0d.b_empty", k), 32'(if_b.empty), 32'd1);
                chk($sformatf("vec%0d.b_count", k), 32'(if_b.count), 32'd0);
            end
        end
        reset = 0; if_a.rd = 0; if_a.wr = 0;

        // Zero-precharge queue: refused read, then a write comes back on the next read
        if_b.rd = 1;
        @(posedge clk); #1;
        if_b.rd = 0;
        chk("b.udf", 32'(if_b.underflow), 32'd1);
        chk("b.valid0", 32'(if_b.valid_1), 32'd0);
        if_b.wr = 1; if_b.entry_1 = 16'h0077;
        @(posedge clk); #1;
        if_b.wr = 0; if_b.rd = 1;
        chk("b.count1", 32'(if_b.count), 32'd1);
        @(posedge clk); #1;
        if_b.rd = 0;
        chk("b.out", 32'(if_b.output_1), 32'h0077);
        chk("b.valid1", 32'(if_b.valid_1), 32'd1);
        chk("b.empty", 32'(if_b.empty), 32'd1);

        // 12 write/read pairs force both pointers around the depth-5 ring
        step(1, 0, 0, 16'h0, "wrap.rst");
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 1, 16'(16'h0100 + i), $sformatf("wrap%0d.w", i));
            step(0, 1, 0, 16'h0, $sformatf("wrap%0d.r", i));
        end

        // Random traffic with occasional resets
        step(1, 0, 0, 16'h0, "rnd.rst");
        for (int i = 0; i < 600; i++) begin
            bit rs, r, w;
            rs = ($urandom_range(0, 99) < 2);
            r  = ($urandom_range(0, 99) < 50);
            w  = ($urandom_range(0, 99) < 55);
            step(rs, r, w, 16'($urandom), $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
